// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared constants and debug FSM encoding for the pCPU register file
package pcpu_pkg;
  localparam int REG_AW = 5;
  localparam int ZERO_REG_DEF = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, RELEASE = 2'd2} dbg_state_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: debug peek/poke handshake between the SoC debug unit and the register file
interface regfile_sb_if #(parameter int WIDTH = 32, parameter int AW = pcpu_pkg::REG_AW) ();
  logic dbg_req;
  logic dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic dbg_ack;
  logic [WIDTH-1:0] dbg_rdata;
  modport master (output dbg_req, dbg_we, dbg_addr, dbg_wdata, input dbg_ack, dbg_rdata);
  modport slave (input dbg_req, dbg_we, dbg_addr, dbg_wdata, output dbg_ack, dbg_rdata);
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writes and per-port busy lookup
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  parameter int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0] rbusy
);
  logic [NREG-1:0] busy;
  // writeback clears, issue sets; the later assignment lets the newer producer win
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else begin
      if (we) busy[wa] <= 1'b0;
      if (iss_valid && !(ZERO_REG != 0 && iss_rd == '0)) busy[iss_rd] <= 1'b1;
    end
  // a same-cycle writeback to the read register satisfies the hazard when forwarded
  always_comb
    for (int i = 0; i < NRD; i++)
      rbusy[i] = busy[ra[i*AW +: AW]]
               & ~(BYPASS != 0 && we && wa == ra[i*AW +: AW])
               & ~(ZERO_REG != 0 && ra[i*AW +: AW] == '0);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with writeback bypass, busy scoreboard and debug port
module regfile_sb import pcpu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NREG = 32,
  parameter int NRD = 3,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0] rbusy,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [WIDTH-1:0] wd,
  input  logic iss_valid,
  input  logic [AW-1:0] iss_rd,
  regfile_sb_if.slave dbg
);
  logic [WIDTH-1:0] regs [NREG];
  dbg_state_t state, state_nx;
  logic dbg_go;
  assign dbg_go = state == IDLE && dbg.dbg_req && !we;
  // combinational read ports: hardwired zero, then forwarded writeback, then storage
  always_comb
    for (int i = 0; i < NRD; i++)
      rd[i*WIDTH +: WIDTH] = (ZERO_REG != 0 && ra[i*AW +: AW] == '0) ? '0 :
                             (BYPASS != 0 && we && wa == ra[i*AW +: AW]) ? wd :
                             regs[ra[i*AW +: AW]];
  // storage: writeback, else a debug poke (only possible while writeback is idle)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (we) begin
      if (!(ZERO_REG != 0 && wa == '0)) regs[wa] <= wd;
    end else if (dbg_go && dbg.dbg_we && !(ZERO_REG != 0 && dbg.dbg_addr == '0))
      regs[dbg.dbg_addr] <= dbg.dbg_wdata;
  // debug state and read-data capture, held until the next debug read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dbg.dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      if (dbg_go && !dbg.dbg_we)
        dbg.dbg_rdata <= (ZERO_REG != 0 && dbg.dbg_addr == '0) ? '0 : regs[dbg.dbg_addr];
    end
  // next state: one ack cycle, then wait for the request to drop so it is serviced once
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = dbg_go ? ACK : IDLE;
      ACK:     state_nx = RELEASE;
      default: state_nx = dbg.dbg_req ? RELEASE : IDLE;
    endcase
  end
  assign dbg.dbg_ack = state == ACK;
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .AW(AW)) u_sb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ra(ra), .rbusy(rbusy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of reads, bypass, scoreboard and debug port
module tb_regfile_sb;
  logic clk = 0;
  logic rst_n;
  logic [14:0] ra;
  logic [95:0] rd0, rd1;
  logic [2:0] rbusy0, rbusy1;
  logic we, iss_valid;
  logic [4:0] wa, iss_rd;
  logic [31:0] wd;
  int passed = 0, total = 0;

  regfile_sb_if #(.WIDTH(32), .AW(5)) dbg0 ();
  regfile_sb_if #(.WIDTH(32), .AW(5)) dbg1 ();

  regfile_sb u0 (.clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd0), .rbusy(rbusy0), .we(we), .wa(wa),
                 .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .dbg(dbg0));
  regfile_sb #(.BYPASS(0)) u1 (.clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd1), .rbusy(rbusy1), .we(we),
                 .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .dbg(dbg1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; ra = '0; we = 0; wa = '0; wd = '0; iss_valid = 0; iss_rd = '0;
    dbg0.dbg_req = 0; dbg0.dbg_we = 0; dbg0.dbg_addr = '0; dbg0.dbg_wdata = '0;
    dbg1.dbg_req = 0; dbg1.dbg_we = 0; dbg1.dbg_addr = '0; dbg1.dbg_wdata = '0;
    #2;
    chk("rst_ack", {95'd0, dbg0.dbg_ack}, 96'd0);
    chk("rst_rdata", {64'd0, dbg0.dbg_rdata}, 96'd0);
    step();
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0], a[4:0]};
      #1;
      chk("rst_rd", rd0, 96'd0);
      chk("rst_rbusy", {93'd0, rbusy0}, 96'd0);
    end
    // plain write then read next cycle
    we = 1; wa = 5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd0, 5'd5};
    step();
    we = 0;
    #1;
    chk("wr5_rd0", rd0[31:0], 32'hDEADBEEF);
    chk("wr5_nobyp", rd1[31:0], 32'hDEADBEEF);
    // register 0 ignores writes and issues
    we = 1; wa = 0; wd = 32'h1234; iss_valid = 1; iss_rd = 0; ra = '0;
    #1;
    chk("zero_rd_same", rd0[31:0], 32'd0);
    step();
    we = 0; iss_valid = 0;
    #1;
    chk("zero_rd_after", rd0[31:0], 32'd0);
    chk("zero_rbusy", {93'd0, rbusy0}, 96'd0);
    // bypass vs no bypass
    we = 1; wa = 7; wd = 32'h11111111;
    step();
    wd = 32'hA5A5A5A5; ra = {5'd0, 5'd7, 5'd0};
    #1;
    chk("byp_rd1", rd0[63:32], 32'hA5A5A5A5);
    chk("byp_rbusy1", {95'd0, rbusy0[1]}, 96'd0);
    chk("nobyp_old", rd1[63:32], 32'h11111111);
    step();
    we = 0;
    #1;
    chk("nobyp_new", rd1[63:32], 32'hA5A5A5A5);
    // scoreboard
    iss_valid = 1; iss_rd = 3; ra = {5'd0, 5'd0, 5'd3}; wd = '0;
    #1;
    chk("sb_not_yet", {95'd0, rbusy0[0]}, 96'd0);
    step();
    iss_valid = 0;
    #1;
    chk("sb_set", {95'd0, rbusy0[0]}, 96'd1);
    we = 1; wa = 3; iss_valid = 1; iss_rd = 3;
    #1;
    chk("sb_byp_mask", {95'd0, rbusy0[0]}, 96'd0);
    chk("sb_nobyp_nomask", {95'd0, rbusy1[0]}, 96'd1);
    step();
    we = 0; iss_valid = 0;
    #1;
    chk("sb_set_wins", {95'd0, rbusy0[0]}, 96'd1);
    we = 1; wa = 3;
    step();
    we = 0;
    #1;
    chk("sb_clear", {95'd0, rbusy0[0]}, 96'd0);
    // debug write blocked by writeback for three cycles
    dbg0.dbg_req = 1; dbg0.dbg_we = 1; dbg0.dbg_addr = 9; dbg0.dbg_wdata = 32'hCAFE0001;
    we = 1; wa = 2; wd = 32'h55;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("dbg_blocked", {95'd0, dbg0.dbg_ack}, 96'd0);
    end
    we = 0;
    step();
    chk("dbg_wr_ack", {95'd0, dbg0.dbg_ack}, 96'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("dbg_held_once", {95'd0, dbg0.dbg_ack}, 96'd0);
    end
    dbg0.dbg_req = 0;
    step();
    ra = {5'd0, 5'd2, 5'd9};
    #1;
    chk("dbg_wr_data", rd0[31:0], 32'hCAFE0001);
    chk("wb_during_dbg", rd0[63:32], 32'h55);
    // debug read
    dbg0.dbg_req = 1; dbg0.dbg_we = 0; dbg0.dbg_addr = 9;
    step();
    chk("dbg_rd_ack", {95'd0, dbg0.dbg_ack}, 96'd1);
    chk("dbg_rd_data", {64'd0, dbg0.dbg_rdata}, {64'd0, 32'hCAFE0001});
    dbg0.dbg_req = 0;
    step();
    chk("dbg_rd_ack_off", {95'd0, dbg0.dbg_ack}, 96'd0);
    chk("dbg_rd_hold", {64'd0, dbg0.dbg_rdata}, {64'd0, 32'hCAFE0001});
    step();
    // reset while in ACK
    iss_valid = 1; iss_rd = 4; dbg0.dbg_req = 1; dbg0.dbg_addr = 5;
    step();
    iss_valid = 0; dbg0.dbg_req = 0; ra = {5'd9, 5'd4, 5'd5};
    #1;
    chk("pre_rst_ack", {95'd0, dbg0.dbg_ack}, 96'd1);
    chk("pre_rst_busy", {95'd0, rbusy0[1]}, 96'd1);
    rst_n = 0;
    #1;
    chk("arst_ack", {95'd0, dbg0.dbg_ack}, 96'd0);
    chk("arst_rd", rd0, 96'd0);
    chk("arst_rbusy", {93'd0, rbusy0}, 96'd0);
    chk("arst_rdata", {64'd0, dbg0.dbg_rdata}, 96'd0);
    step();
    rst_n = 1;
    step();
    chk("post_rst_idle", {95'd0, dbg0.dbg_ack}, 96'd0);
    dbg0.dbg_req = 1; dbg0.dbg_addr = 9;
    step();
    chk("post_rst_ack", {95'd0, dbg0.dbg_ack}, 96'd1);
    chk("post_rst_rdata", {64'd0, dbg0.dbg_rdata}, 96'd0);
    dbg0.dbg_req = 0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
